ysyx_24100029_wbu: RTL and testbench
====================================

Name: ysyx_24100029_wbu

Overview:
Writeback unit, directly upstream of the architectural register file. It accepts completed instructions from LSU/EXU over a valid/ready handshake and buffers them in a 2-entry FIFO. Load data is extracted and sign/zero-extended on enqueue. On commit it drives the register-file write port (wen/waddr/wdata) and exposes pending-rd info to decode for hazard stalls.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, register/data width (must be 32; load extraction assumes a 32-bit word)

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream entry valid
in_ready  out  1  WBU can accept
in_rd  in  ADDR_WIDTH  destination register
in_rd_wen  in  1  instruction writes rd
in_is_load  in  1  result comes from load data
in_funct3  in  3  load size/sign encoding
in_addr_lo  in  2  load address bits [1:0]
in_result  in  DATA_WIDTH  ALU/CSR/link result
in_load_word  in  DATA_WIDTH  raw aligned memory word
in_pc  in  32  instruction PC
commit_valid  out  1  head entry ready to retire
commit_ready  in  1  retire/trace side accepts
commit_pc  out  32  PC of retiring instruction
wen  out  1  register-file write enable
waddr  out  ADDR_WIDTH  register-file write address
wdata  out  DATA_WIDTH  register-file write data
pend0_valid, pend1_valid  out  1 each  FIFO slot occupied with rd write pending (rd != 0)
pend0_rd, pend1_rd  out  ADDR_WIDTH each  rd of the slot
load_err  out  1  sticky: illegal load funct3 seen
retire_cnt  out  64  retired-instruction count (optional feature)

Behaviour:
- FIFO: 2 entries, head/tail pointers plus a 2-bit count. Enqueue when in_valid && in_ready; dequeue when commit_valid && commit_ready.
- in_ready = (count != 2). Registered-state only; no combinational path from commit_ready. When full, an enqueue in the same cycle as a dequeue is refused; in_ready rises the next cycle.
- Simultaneous enqueue and dequeue at count 1: count stays 1, pointers both advance.
- commit_valid = (count != 0). Head fields drive commit_pc/waddr/wdata combinationally.
- wen = commit_valid && commit_ready && head.rd_wen && head.rd != 0. x0 writes are suppressed, but the instruction still commits.
- Load extraction (applied at enqueue when in_is_load; the stored data is final):
  - 000 lb: byte at addr_lo, sign-extended.
  - 100 lbu: byte at addr_lo, zero-extended.
  - 001 lh: half selected by addr_lo[1] (addr_lo[0] ignored), sign-extended.
  - 101 lhu: same half, zero-extended.
  - 010 lw: the full word.
  - Any other funct3: store the raw word and set load_err (sticky until reset).
- Non-load: data = in_result.
- pendN_valid reflects physical slot N (valid && rd_wen && rd != 0), independent of head position.
- Reset (asynchronous, at any time, including mid-commit):
  - count=0, pointers=0, load_err=0, retire_cnt=0.
  - Hence in_ready=1, commit_valid=0, wen=0, waddr=0, wdata=0, pend*=0.
  - In-flight entries are discarded and no write is issued.
- Latency: one instruction enqueued into an empty FIFO appears on commit_valid the next cycle. Throughput is 1 instruction/cycle while commit_ready=1.

Optional Feature:
YSYX_WBU_RETIRE_CNT_EN:
- Defined: a 64-bit counter increments on every commit handshake, including x0 and non-writing instructions. It wraps silently at 2^64-1 -> 0 and is driven on retire_cnt.
- Undefined: no counter is instantiated and retire_cnt is tied to 0.

Decomposition:
- Shared package ysyx_24100029_pkg holds the funct3 load encodings (LB/LH/LW/LBU/LHU), the FIFO depth constant (2) and the wb-entry struct typedef {pc, rd, rd_wen, data}.
- One natural sub-module, ysyx_24100029_load_ext: a pure combinational extractor (funct3, addr_lo, word -> data, illegal).
- The FIFO stays inline.

Test Plan:
- lb from word 0x80FF7F01 at addr_lo=2: wdata=0xFFFFFFFF. At addr_lo=0 with lbu: wdata=0x00000001. lh at addr_lo=3: wdata=0xFFFF80FF.
- Non-load, rd=0, rd_wen=1, result=0x1234, commit_ready=1: commit_valid pulses, wen=0, retire_cnt +1 (feature on).
- Hold commit_ready=0, push 3 entries back-to-back: first two accepted, in_ready=0 on the third. Release commit_ready: commits in order, third accepted one cycle after the first dequeue.
- Streaming, commit_ready=1 and in_valid=1 for 10 cycles: 10 commits in 10 cycles after the 1-cycle fill, waddr/wdata match in order.
- Assert reset asynchronously (mid-cycle) with 2 entries pending: wen, commit_valid and pend* drop to 0 immediately. After release, in_ready=1 and no stale write occurs.
- in_is_load with funct3=011: wdata = raw word, load_err=1, and it stays 1 until reset.

Source files
------------

// File: rtl/ysyx_24100029_pkg.sv
// Shared types and constants for the writeback unit: load funct3 encodings,
// FIFO depth and the buffered writeback entry layout.
package ysyx_24100029_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;
    localparam int WB_DEPTH  = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [31:0]          pc;
        logic [WB_ADDR_W-1:0] rd;
        logic                 rd_wen;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ysyx_24100029_load_ext.sv
// Combinational load-data extractor: selects the byte/half addressed by
// addr_lo from an aligned word and sign/zero-extends it per funct3.
module ysyx_24100029_load_ext
    import ysyx_24100029_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // Halfword choice ignores addr_lo[0]; misaligned halves are not split.
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data    = word;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            F3_LW:   data = word;
            default: begin
                data    = word;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_24100029_wbu.sv
// Writeback unit: 2-entry FIFO between LSU/EXU and the register file.
// Optional retired-instruction counter enabled by YSYX_WBU_RETIRE_CNT_EN.
module ysyx_24100029_wbu
    import ysyx_24100029_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [DATA_WIDTH-1:0] in_load_word,
    input  logic [31:0]           in_pc,
    output logic                  commit_valid,
    input  logic                  commit_ready,
    output logic [31:0]           commit_pc,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  pend0_valid,
    output logic                  pend1_valid,
    output logic [ADDR_WIDTH-1:0] pend0_rd,
    output logic [ADDR_WIDTH-1:0] pend1_rd,
    output logic                  load_err,
    output logic [63:0]           retire_cnt
);

    wb_entry_t   fifo [WB_DEPTH];
    wb_entry_t   new_entry;
    wb_entry_t   head_e;
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic        enq;
    logic        deq;
    logic [31:0] ext_data;
    logic        ext_illegal;
    logic [1:0]  occ;

    ysyx_24100029_load_ext u_load_ext (
        .funct3  (in_funct3),
        .addr_lo (in_addr_lo),
        .word    (in_load_word),
        .data    (ext_data),
        .illegal (ext_illegal)
    );

    assign in_ready     = (count != 2'(WB_DEPTH));
    assign commit_valid = (count != 2'd0);
    assign enq          = in_valid && in_ready;
    assign deq          = commit_valid && commit_ready;

    always_comb begin
        new_entry        = '0;
        new_entry.pc     = in_pc;
        new_entry.rd     = in_rd;
        new_entry.rd_wen = in_rd_wen;
        new_entry.data   = in_is_load ? ext_data : in_result;
    end

    // Entry payload carries no reset; occupancy is tracked by count/head only.
    always_ff @(posedge clock) begin
        if (enq) begin
            fifo[tail] <= new_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head     <= 1'b0;
            tail     <= 1'b0;
            count    <= 2'd0;
            load_err <= 1'b0;
        end else begin
            if (enq) begin
                tail <= ~tail;
            end
            if (deq) begin
                head <= ~head;
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (enq && in_is_load && ext_illegal) begin
                load_err <= 1'b1;
            end
        end
    end

    assign head_e    = fifo[head];
    assign commit_pc = commit_valid ? head_e.pc : 32'd0;
    assign waddr     = commit_valid ? head_e.rd : '0;
    assign wdata     = commit_valid ? head_e.data : '0;
    assign wen       = deq && head_e.rd_wen && (head_e.rd != '0);

    // Physical slot occupancy, independent of which slot is currently the head.
    assign occ[0] = (count == 2'd2) || ((count == 2'd1) && (head == 1'b0));
    assign occ[1] = (count == 2'd2) || ((count == 2'd1) && (head == 1'b1));

    assign pend0_valid = occ[0] && fifo[0].rd_wen && (fifo[0].rd != '0);
    assign pend1_valid = occ[1] && fifo[1].rd_wen && (fifo[1].rd != '0);
    assign pend0_rd    = occ[0] ? fifo[0].rd : '0;
    assign pend1_rd    = occ[1] ? fifo[1].rd : '0;

`ifdef YSYX_WBU_RETIRE_CNT_EN
    logic [63:0] retire_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_q <= 64'd0;
        end else if (deq) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_24100029_wbu.sv
// Scoreboard bench for the writeback unit: expected commits are queued on
// accepted enqueues and compared as the DUT retires them.
module tb_ysyx_24100029_wbu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic [31:0] in_result = '0;
    logic [31:0] in_load_word = '0;
    logic [31:0] in_pc = '0;
    logic        commit_valid;
    logic        commit_ready = 1'b0;
    logic [31:0] commit_pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        pend0_valid;
    logic        pend1_valid;
    logic [4:0]  pend0_rd;
    logic [4:0]  pend1_rd;
    logic        load_err;
    logic [63:0] retire_cnt;

    ysyx_24100029_wbu dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_rd_wen    (in_rd_wen),
        .in_is_load   (in_is_load),
        .in_funct3    (in_funct3),
        .in_addr_lo   (in_addr_lo),
        .in_result    (in_result),
        .in_load_word (in_load_word),
        .in_pc        (in_pc),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_pc    (commit_pc),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .pend0_valid  (pend0_valid),
        .pend1_valid  (pend1_valid),
        .pend0_rd     (pend0_rd),
        .pend1_rd     (pend1_rd),
        .load_err     (load_err),
        .retire_cnt   (retire_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          commits = 0;
    logic [63:0] ret_model = 64'd0;
    logic [31:0] cur_exp = '0;
    logic        last_acc = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
        logic [31:0] sb_w;
        logic [31:0] sh_w;
        sb_w = w >> (8 * a);
        sh_w = a[1] ? (w >> 16) : w;
        case (f3)
            3'b000:  return {{24{sb_w[7]}}, sb_w[7:0]};
            3'b100:  return {24'd0, sb_w[7:0]};
            3'b001:  return {{16{sh_w[15]}}, sh_w[15:0]};
            3'b101:  return {16'd0, sh_w[15:0]};
            default: return w;
        endcase
    endfunction

    // One clock: score the commit/enqueue seen at the falling edge, then step.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (commit_valid && commit_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", commit_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("commit_pc", commit_pc, e.pc);
                chk("waddr", waddr, e.rd);
                chk("wdata", wdata, e.data);
                chk("wen", wen, e.wen);
            end
`ifdef YSYX_WBU_RETIRE_CNT_EN
            chk("retire_cnt", retire_cnt, ret_model);
`else
            chk("retire_cnt", retire_cnt, 64'd0);
`endif
            ret_model++;
            commits++;
        end else begin
            chk("wen_idle", wen, 1'b0);
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            sb.push_back('{in_pc, in_rd, in_rd_wen && (in_rd != 5'd0), cur_exp});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [4:0] rd, input logic rdw,
                          input logic ld, input logic [2:0] f3, input logic [1:0] alo,
                          input logic [31:0] res, input logic [31:0] word,
                          input logic [31:0] exp);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_rd        = rd;
        in_rd_wen    = rdw;
        in_is_load   = ld;
        in_funct3    = f3;
        in_addr_lo   = alo;
        in_result    = res;
        in_load_word = word;
        cur_exp      = exp;
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] rd, input logic rdw,
                        input logic ld, input logic [2:0] f3, input logic [1:0] alo,
                        input logic [31:0] res, input logic [31:0] word,
                        input logic [31:0] exp);
        set_in(pc, rd, rdw, ld, f3, alo, res, word, exp);
        for (int t = 0; t < 20; t++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", in_ready, 1'b1);
    endtask

    task automatic drain();
        in_valid     = 1'b0;
        commit_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (sb.size() == 0 && !commit_valid) break;
            tick();
        end
        chk("drain_valid", commit_valid, 1'b0);
        chk("drain_sb", sb.size(), 0);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_commit_valid", commit_valid, 1'b0);
        chk("rst_wen", wen, 1'b0);
        chk("rst_waddr", waddr, 5'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_pend", {pend0_valid, pend1_valid}, 2'b00);
        chk("rst_load_err", load_err, 1'b0);
        chk("rst_retire_cnt", retire_cnt, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Backpressure: two accepted while blocked, third refused until a slot frees.
        commit_ready = 1'b0;
        send(32'h100, 5'd3, 1'b1, 1'b0, 3'b000, 2'd0, 32'hA0, 32'h0, 32'hA0);
        send(32'h104, 5'd4, 1'b1, 1'b0, 3'b000, 2'd0, 32'hA1, 32'h0, 32'hA1);
        set_in(32'h108, 5'd5, 1'b1, 1'b0, 3'b000, 2'd0, 32'hA2, 32'h0, 32'hA2);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_pend0", {pend0_valid, pend0_rd}, {1'b1, 5'd3});
        chk("full_pend1", {pend1_valid, pend1_rd}, {1'b1, 5'd4});
        tick();
        chk("full_refused", last_acc, 1'b0);
        commit_ready = 1'b1;
        #1;
        chk("full_no_comb_ready", in_ready, 1'b0);
        tick();
        chk("full_refused_on_deq", last_acc, 1'b0);
        chk("ready_after_deq", in_ready, 1'b1);
        tick();
        chk("third_accepted", last_acc, 1'b1);
        drain();

        // Load extraction.
        commit_ready = 1'b1;
        send(32'h200, 5'd10, 1'b1, 1'b1, 3'b000, 2'd2, 32'h0, 32'h80FF7F01, 32'hFFFFFFFF);
        send(32'h204, 5'd11, 1'b1, 1'b1, 3'b100, 2'd0, 32'h0, 32'h80FF7F01, 32'h00000001);
        send(32'h208, 5'd12, 1'b1, 1'b1, 3'b001, 2'd3, 32'h0, 32'h80FF7F01, 32'hFFFF80FF);
        send(32'h20C, 5'd13, 1'b1, 1'b1, 3'b101, 2'd2, 32'h0, 32'h80FF7F01, 32'h000080FF);
        send(32'h210, 5'd14, 1'b1, 1'b1, 3'b001, 2'd1, 32'h0, 32'h80FF7F01, 32'h00007F01);
        send(32'h214, 5'd15, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'h80FF7F01, 32'h80FF7F01);
        send(32'h218, 5'd16, 1'b1, 1'b1, 3'b000, 2'd1, 32'h0, 32'h12348056,
             ext_model(3'b000, 2'd1, 32'h12348056));
        // x0 destination and a non-writing instruction still commit, with no write.
        send(32'h21C, 5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h1234, 32'h0, 32'h1234);
        send(32'h220, 5'd17, 1'b0, 1'b0, 3'b000, 2'd0, 32'h5555, 32'h0, 32'h5555);
        drain();
        chk("load_err_clean", load_err, 1'b0);

        // Streaming at one instruction per cycle.
        begin
            int c0;
            c0 = commits;
            for (int i = 0; i < 10; i++) begin
                send(32'h300 + 32'(i * 4), 5'(i + 1), 1'b1, 1'b0, 3'b000, 2'd0,
                     32'hC000 + 32'(i), 32'h0, 32'hC000 + 32'(i));
            end
            in_valid = 1'b0;
            tick();
            chk("stream_commits", commits - c0, 10);
        end
        drain();

        // Asynchronous reset mid-commit with two entries pending.
        commit_ready = 1'b0;
        send(32'h400, 5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 32'hD0, 32'h0, 32'hD0);
        send(32'h404, 5'd8, 1'b1, 1'b0, 3'b000, 2'd0, 32'hD1, 32'h0, 32'hD1);
        in_valid = 1'b0;
        commit_ready = 1'b1;
        #1;
        chk("pre_rst_wen", wen, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_wen", wen, 1'b0);
        chk("arst_commit_valid", commit_valid, 1'b0);
        chk("arst_pend", {pend0_valid, pend1_valid}, 2'b00);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_wdata", wdata, 32'd0);
        sb.delete();
        ret_model = 64'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_commit_valid", commit_valid, 1'b0);

        // Illegal load funct3: raw word stored, sticky error flag.
        commit_ready = 1'b1;
        send(32'h500, 5'd9, 1'b1, 1'b1, 3'b011, 2'd1, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
        drain();
        chk("load_err_set", load_err, 1'b1);
        send(32'h504, 5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'h01020304, 32'h01020304);
        drain();
        repeat (2) tick();
        chk("load_err_sticky", load_err, 1'b1);
        reset = 1'b1;
        #1;
        chk("load_err_cleared", load_err, 1'b0);
        sb.delete();
        ret_model = 64'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
